// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl_if
// Brief    : MEM-stage request and data-memory handshake bundle for data_mem_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
) ();
  // Pipeline side
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [2:0]            MEM_FUNC3;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [31:0]           MEM_WRITE_DATA;
  logic [31:0]           MEM_READ_DATA;
  logic                  BUSY;
  logic                  MISALIGNED;
  // Memory side
  logic                  DM_REQ;
  logic                  DM_WE;
  logic [ADDR_WIDTH-3:0] DM_ADDR;
  logic [31:0]           DM_WDATA;
  logic [3:0]            DM_BYTE_EN;
  logic                  DM_ACK;
  logic [31:0]           DM_RDATA;

  // Controller view: consumes the pipeline request, masters the memory bus.
  modport master (
    input  MEM_READ, MEM_WRITE, MEM_FUNC3, MEM_ADDR, MEM_WRITE_DATA,
    input  DM_ACK, DM_RDATA,
    output MEM_READ_DATA, BUSY, MISALIGNED,
    output DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BYTE_EN
  );

  modport slave (
    output MEM_READ, MEM_WRITE, MEM_FUNC3, MEM_ADDR, MEM_WRITE_DATA,
    output DM_ACK, DM_RDATA,
    input  MEM_READ_DATA, BUSY, MISALIGNED,
    input  DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BYTE_EN
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : RV32IM MEM-stage data memory controller: req/ack handshake,
//            store lane formatting, load extension, pipeline stall (BUSY).
//            Optional misalignment trap enabled by defining MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  data_mem_ctrl_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  state_t                r_state;
  logic                  r_dm_req;
  logic                  r_dm_we;
  logic [ADDR_WIDTH-3:0] r_dm_addr;
  logic [31:0]           r_dm_wdata;
  logic [3:0]            r_dm_byte_en;
  logic [2:0]            r_func3;
  logic [1:0]            r_addr_lo;
  logic [31:0]           r_read_data;
  logic                  r_misaligned;

  logic                  w_req;
  logic                  w_trap;
  logic [3:0]            w_st_be;
  logic [31:0]           w_st_wdata;
  logic [7:0]            w_ld_byte;
  logic [15:0]           w_ld_half;
  logic [31:0]           w_ld_data;

  assign w_req = bus.MEM_READ | bus.MEM_WRITE;

`ifdef MISALIGN_TRAP_EN
  logic w_is_half;
  logic w_is_word;

  // Access size follows the store table for writes and the load table for reads.
  always_comb begin
    w_is_half = 1'b0;
    w_is_word = 1'b0;
    if (bus.MEM_WRITE) begin
      w_is_half = (bus.MEM_FUNC3 == 3'b001);
      w_is_word = (bus.MEM_FUNC3 != 3'b000) && (bus.MEM_FUNC3 != 3'b001);
    end else begin
      w_is_half = (bus.MEM_FUNC3[1:0] == 2'b01);
      w_is_word = (bus.MEM_FUNC3[1:0] != 2'b00) && (bus.MEM_FUNC3[1:0] != 2'b01);
    end
  end

  assign w_trap = (w_is_half & bus.MEM_ADDR[0]) |
                  (w_is_word & (bus.MEM_ADDR[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Store lane formatting from the live request, registered on IDLE -> ACCESS.
  always_comb begin
    w_st_be    = 4'b1111;
    w_st_wdata = bus.MEM_WRITE_DATA;
    case (bus.MEM_FUNC3)
      3'b000: begin
        w_st_be    = 4'b0001 << bus.MEM_ADDR[1:0];
        w_st_wdata = {4{bus.MEM_WRITE_DATA[7:0]}};
      end
      3'b001: begin
        w_st_be    = bus.MEM_ADDR[1] ? 4'b1100 : 4'b0011;
        w_st_wdata = {2{bus.MEM_WRITE_DATA[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = bus.MEM_WRITE_DATA;
      end
    endcase
    if (!bus.MEM_WRITE) begin
      w_st_be = 4'b0000;
    end
  end

  // Load extension uses the size/offset latched when the request was issued.
  always_comb begin
    w_ld_byte = bus.DM_RDATA[7:0];
    case (r_addr_lo)
      2'b00:   w_ld_byte = bus.DM_RDATA[7:0];
      2'b01:   w_ld_byte = bus.DM_RDATA[15:8];
      2'b10:   w_ld_byte = bus.DM_RDATA[23:16];
      default: w_ld_byte = bus.DM_RDATA[31:24];
    endcase
    w_ld_half = r_addr_lo[1] ? bus.DM_RDATA[31:16] : bus.DM_RDATA[15:0];
    case (r_func3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_data = {24'h000000, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_data = {16'h0000, w_ld_half};
      default: w_ld_data = bus.DM_RDATA;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_dm_req     <= 1'b0;
      r_dm_we      <= 1'b0;
      r_dm_addr    <= '0;
      r_dm_wdata   <= 32'h0000_0000;
      r_dm_byte_en <= 4'b0000;
      r_func3      <= 3'b000;
      r_addr_lo    <= 2'b00;
      r_read_data  <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_trap) begin
              r_state      <= S_DONE;
              r_misaligned <= 1'b1;
              r_read_data  <= 32'h0000_0000;
            end else begin
              r_state      <= S_ACCESS;
              r_dm_req     <= 1'b1;
              r_dm_we      <= bus.MEM_WRITE;
              r_dm_addr    <= bus.MEM_ADDR[ADDR_WIDTH-1:2];
              r_dm_wdata   <= w_st_wdata;
              r_dm_byte_en <= w_st_be;
              r_func3      <= bus.MEM_FUNC3;
              r_addr_lo    <= bus.MEM_ADDR[1:0];
            end
          end
        end
        S_ACCESS: begin
          if (bus.DM_ACK) begin
            r_state     <= S_DONE;
            r_dm_req    <= 1'b0;
            r_read_data <= r_dm_we ? 32'h0000_0000 : w_ld_data;
          end
        end
        S_DONE: begin
          // Always fall back to IDLE so the held request is not re-issued.
          r_state      <= S_IDLE;
          r_misaligned <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_dm_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY          = w_req & (r_state != S_DONE);
  assign bus.MEM_READ_DATA = r_read_data;
  assign bus.MISALIGNED    = r_misaligned;
  assign bus.DM_REQ        = r_dm_req;
  assign bus.DM_WE         = r_dm_we;
  assign bus.DM_ADDR       = r_dm_addr;
  assign bus.DM_WDATA      = r_dm_wdata;
  assign bus.DM_BYTE_EN    = r_dm_byte_en;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Self-checking bench for data_mem_ctrl: directed plan plus random
//            accesses against a behavioural load/store model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int AW = 32;

  typedef struct {
    int          busy;
    int          rises;
    int          reqcyc;
    logic [31:0] data;
    logic        mis;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        stable;
    logic        done;
  } res_t;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  data_mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  data_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int load_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int store_size(input logic [2:0] f3);
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int lane_off(input int size, input logic [1:0] lo);
    if (size == 1) return int'(lo);
    if (size == 2) return lo[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic is_trap(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
`ifdef MISALIGN_TRAP_EN
    int s;
    s = wr ? store_size(f3) : load_size(f3);
    return ((s == 2) && lo[0]) || ((s == 4) && (lo != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] word);
    int          size;
    logic [31:0] mask;
    logic [31:0] v;
    size = load_size(f3);
    if (size == 4) return word;
    mask = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (word >> (8 * lane_off(size, lo))) & mask;
    if (!f3[2] && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input int size, input logic [1:0] lo);
    logic [3:0] be;
    int off;
    off = lane_off(size, lo);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + size);
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] wd);
    if (size == 1) return {4{wd[7:0]}};
    if (size == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  // ---------------- driver + memory responder ----------------
  // Call at a negedge; returns at the negedge of the DONE cycle with requests dropped.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rword, input int waits, output res_t r);
    int   w;
    logic prev_req;
    logic acked;
    r = '{busy: 0, rises: 0, reqcyc: 0, data: 32'hx, mis: 1'bx, we: 1'bx, addr: 32'hx,
          be: 4'hx, wd: 32'hx, stable: 1'b1, done: 1'b0};
    bus.MEM_READ       = rd;
    bus.MEM_WRITE      = wr;
    bus.MEM_FUNC3      = f3;
    bus.MEM_ADDR       = addr;
    bus.MEM_WRITE_DATA = wd;
    bus.DM_ACK         = 1'b0;
    w        = waits;
    acked    = 1'b0;
    prev_req = bus.DM_REQ;
    #1;
    if (bus.BUSY) r.busy++;
    for (int c = 0; c < 64 && !r.done; c++) begin
      @(negedge CLK);
      bus.DM_ACK   = 1'b0;
      bus.DM_RDATA = $urandom;
      if (!bus.BUSY) begin
        r.done = 1'b1;
        r.data = bus.MEM_READ_DATA;
        r.mis  = bus.MISALIGNED;
      end else begin
        r.busy++;
        if (bus.DM_REQ) begin
          if (!prev_req) begin
            r.rises++;
            r.we   = bus.DM_WE;
            r.addr = {2'b00, bus.DM_ADDR};
            r.be   = bus.DM_BYTE_EN;
            r.wd   = bus.DM_WDATA;
          end else if (r.we !== bus.DM_WE || r.addr !== {2'b00, bus.DM_ADDR} ||
                       r.be !== bus.DM_BYTE_EN || r.wd !== bus.DM_WDATA) begin
            r.stable = 1'b0;
          end
          r.reqcyc++;
          if (w == 0 && !acked) begin
            bus.DM_ACK   = 1'b1;
            bus.DM_RDATA = rword;
            acked        = 1'b1;
          end else begin
            w--;
          end
        end
      end
      prev_req = bus.DM_REQ;
    end
    bus.MEM_READ  = 1'b0;
    bus.MEM_WRITE = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rword,
                        input int waits, output res_t r);
    logic trap;
    int   ssz;
    trap = is_trap(wr, f3, addr[1:0]);
    ssz  = store_size(f3);
    do_access(rd, wr, f3, addr, wd, rword, waits, r);
    check($sformatf("%s_done", tag), {31'b0, r.done}, 32'd1);
    check($sformatf("%s_busy", tag), r.busy, trap ? 1 : waits + 2);
    check($sformatf("%s_req_count", tag), r.rises, trap ? 0 : 1);
    check($sformatf("%s_misaligned", tag), {31'b0, r.mis}, {31'b0, trap});
    check($sformatf("%s_rdata", tag), r.data,
          (trap || wr) ? 32'h0 : ref_load(f3, addr[1:0], rword));
    if (!trap) begin
      check($sformatf("%s_req_cycles", tag), r.reqcyc, waits + 1);
      check($sformatf("%s_we", tag), {31'b0, r.we}, {31'b0, wr});
      check($sformatf("%s_dm_addr", tag), r.addr, addr >> 2);
      check($sformatf("%s_byte_en", tag), {28'b0, r.be},
            {28'b0, wr ? ref_be(ssz, addr[1:0]) : 4'b0000});
      check($sformatf("%s_stable", tag), {31'b0, r.stable}, 32'd1);
      if (wr) check($sformatf("%s_wdata", tag), r.wd, ref_wdata(ssz, wd));
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    res_t        r;
    res_t        r2;
    logic [31:0] held;
    bus.MEM_READ       = 1'b0;
    bus.MEM_WRITE      = 1'b0;
    bus.MEM_FUNC3      = 3'b000;
    bus.MEM_ADDR       = 32'h0;
    bus.MEM_WRITE_DATA = 32'h0;
    bus.DM_ACK         = 1'b0;
    bus.DM_RDATA       = 32'h0;
    RST                = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_dm_req",     {31'b0, bus.DM_REQ}, 32'd0);
    check("rst_dm_we",      {31'b0, bus.DM_WE}, 32'd0);
    check("rst_dm_addr",    {2'b00, bus.DM_ADDR}, 32'd0);
    check("rst_dm_wdata",   bus.DM_WDATA, 32'd0);
    check("rst_byte_en",    {28'b0, bus.DM_BYTE_EN}, 32'd0);
    check("rst_read_data",  bus.MEM_READ_DATA, 32'd0);
    check("rst_misaligned", {31'b0, bus.MISALIGNED}, 32'd0);
    check("rst_busy",       {31'b0, bus.BUSY}, 32'd0);
    RST = 1'b0;

    // LB sign-extended, zero wait
    @(negedge CLK);
    run_op("lb", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, r);
    check("lb_value", r.data, 32'hFFFF_FF80);
    check("lb_addr",  r.addr, 32'h0000_0400);
    check("lb_stall", r.busy, 2);

    // Reset in the middle of an access
    @(negedge CLK);
    bus.MEM_READ  = 1'b1;
    bus.MEM_FUNC3 = 3'b010;
    bus.MEM_ADDR  = 32'h0000_0040;
    @(negedge CLK);
    check("midrst_pre_req", {31'b0, bus.DM_REQ}, 32'd1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("midrst_req",   {31'b0, bus.DM_REQ}, 32'd0);
    check("midrst_rdata", bus.MEM_READ_DATA, 32'd0);
    check("midrst_busy_hi", {31'b0, bus.BUSY}, 32'd1);
    bus.MEM_READ = 1'b0;
    #1;
    check("midrst_busy_lo", {31'b0, bus.BUSY}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_idle_req", {31'b0, bus.DM_REQ}, 32'd0);

    // Stray ACK while idle must not start or complete anything
    held = bus.MEM_READ_DATA;
    bus.DM_ACK   = 1'b1;
    bus.DM_RDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    bus.DM_ACK = 1'b0;
    @(negedge CLK);
    check("idle_ack_req",   {31'b0, bus.DM_REQ}, 32'd0);
    check("idle_ack_rdata", bus.MEM_READ_DATA, held);

    // LHU with three wait cycles
    run_op("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 3, r);
    check("lhu_value", r.data, 32'h0000_BEEF);
    check("lhu_stall", r.busy, 5);

    // SB lane replication
    @(negedge CLK);
    run_op("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0, 0, r);
    check("sb_be",    {28'b0, r.be}, 32'h0000_0002);
    check("sb_wdata", r.wd, 32'hABAB_ABAB);

    // SW then LW back to back, two waits each; LW issued in the SW DONE cycle
    @(negedge CLK);
    run_op("b2b_sw", 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h1234_5678, 32'h0, 2, r);
    run_op("b2b_lw", 1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 2, r2);
    check("b2b_total_reqs", r.rises + r2.rises, 2);

    // Read and write together is a write
    @(negedge CLK);
    run_op("rw_both", 1'b1, 1'b1, 3'b001, 32'h0000_0302, 32'h0000_5A5A, 32'h1111_2222, 1, r);

    // Misaligned word
    @(negedge CLK);
    run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h8765_4321, 0, r);
`ifdef MISALIGN_TRAP_EN
    check("lw_mis_trap_stall", r.busy, 1);
    @(negedge CLK);
    check("lw_mis_one_cycle", {31'b0, bus.MISALIGNED}, 32'd0);
`else
    check("lw_mis_word", r.data, 32'h8765_4321);
`endif

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      logic        rd;
      logic        wr;
      int          k;
      k  = $urandom_range(0, 3);
      rd = (k != 1);
      wr = (k != 0);
      if ($urandom_range(0, 1) == 1) @(negedge CLK);
      run_op($sformatf("rnd%0d", n), rd, wr, 3'($urandom_range(0, 7)), $urandom,
             $urandom, $urandom, $urandom_range(0, 3), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
